// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: FSM state encoding, mouse command bytes, frame builder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_EN_REPORT = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE  = 8'hF3;
    localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;

    // Host-to-device frame as shifted out after the start bit:
    // bits 7:0 data (LSB first), bit 8 odd parity, bit 9 stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pad synchronizer: 2-flop sync of clock and data plus falling-edge detect on clock.
// Latency: synced levels 2 cycles after the pad; clk_fall is a 1-cycle pulse 2-3 cycles after the pad edge.
// Backpressure: none; free-running sampler.
//
// Ports: clk/rstn system clock and async active-low reset; ps2_clk/ps2_data raw pad levels;
//        clk_s/data_s synchronized levels; clk_fall single-cycle pulse on a synced clock 1->0.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);

    logic [1:0] clk_sync_q,  clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       clk_prev_q,  clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
    end

    // Reset to the idle-bus level (high) so leaving reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, device ACK.
// Latency: INHIBIT_CYCLES + 1 cycles of host-driven request, then paced by the device clock.
// Backpressure: tx_ready is high only in IDLE; one byte accepted per IDLE visit, tx_valid ignored while busy.
//
// Ports: clk/rstn clock and async active-low reset; tx_valid/tx_data/tx_ready byte handshake;
//        ps2_clk/ps2_data pad levels in; ps2_clk_oe/ps2_data_oe open-drain pull-low enables out;
//        rx_inhibit tells the receiver to ignore the bus; tx_done/ack_err/timeout_err 1-cycle status pulses.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       ack_err,
    output logic       timeout_err
);

    // One counter serves both the inhibit hold and the device timeout; they never overlap.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    sh_q, sh_d;
    logic [3:0]    idx_q, idx_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ack_bad_q, ack_bad_d;
    logic          tx_done_q, tx_done_d;
    logic          ack_err_q, ack_err_d;
    logic          timeout_err_q, timeout_err_d;

    logic clk_s, data_s, clk_fall;

    ps2_line_sync u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fall (clk_fall)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_d          = sh_q;
        idx_d         = idx_q;
        clk_oe_d      = clk_oe_q;
        data_oe_d     = data_oe_q;
        ack_bad_d     = ack_bad_q;
        tx_done_d     = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    sh_d      = ps2_frame(tx_data);
                    state_d   = INHIBIT;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    ack_bad_d = 1'b0;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d   = REQ;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REQ: begin
                // Release the clock with data still low: that is the start bit.
                state_d  = SHIFT;
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
            end
            SHIFT, ACK, WAIT_IDLE: begin
                if (cnt_q == TO_LAST) begin
                    // Timeout wins over any clock edge seen in the same cycle.
                    state_d       = IDLE;
                    clk_oe_d      = 1'b0;
                    data_oe_d     = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (state_q == SHIFT) begin
                        if (clk_fall) begin
                            data_oe_d = ~sh_q[idx_q];
                            idx_d     = idx_q + 4'd1;
                            if (idx_q == 4'd9) begin
                                state_d = ACK;
                            end
                        end
                    end else if (state_q == ACK) begin
                        if (clk_fall) begin
                            state_d = WAIT_IDLE;
                            if (data_s) begin
                                ack_err_d = 1'b1;
                                ack_bad_d = 1'b1;
                            end
                        end
                    end else begin
                        if (clk_s && data_s) begin
                            state_d   = IDLE;
                            tx_done_d = ~ack_bad_q;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sh_q          <= '0;
            idx_q         <= '0;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            ack_bad_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_q          <= sh_d;
            idx_q         <= idx_d;
            clk_oe_q      <= clk_oe_d;
            data_oe_q     <= data_oe_d;
            ack_bad_q     <= ack_bad_d;
            tx_done_q     <= tx_done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign rx_inhibit  = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = tx_done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;

endmodule
